rs_encoder: RTL
===============

Name: rs_encoder

Overview:
- Systematic RS(255,239) encoder over GF(2^8), t=8. It is the transmit-side counterpart of the decoder chain (syndrome, BM, Chien search).
- Accepts a 239-symbol message stream and passes each message symbol straight to the output.
- After the last message symbol, it appends 16 parity symbols computed by an LFSR division by g(x). Output frames are 255 symbols, contiguous.

Parameters:
- n, 255, code frame length in symbols
- k, 239, message symbols per frame
- t, 8, correctable symbols; parity count is 2t=16
- m, 8, symbol width in bits

Ports:
- sys_clk  input  1  single clock, rising edge
- sys_rst_n  input  1  asynchronous active-low reset
- din  input  m  message symbol
- din_valid  input  1  din is valid this cycle
- din_sop  input  1  first message symbol of a frame; qualified by din_valid
- din_ready  output  1  encoder accepts a symbol this cycle; a symbol is accepted when din_valid & din_ready
- dout  output  m  codeword symbol, registered
- dout_valid  output  1  dout is valid
- dout_sop  output  1  dout is codeword symbol 0
- dout_eop  output  1  dout is codeword symbol 254, the last parity symbol
- dout_parity  output  1  dout is a parity symbol
- frame_abort  output  1  one-cycle pulse: the current frame was abandoned because of a new din_sop

Behaviour:
- Field and code:
  - Primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D); alpha = 0x02.
  - g(x) = prod_{i=0..15}(x + alpha^i). This root set is the one the decoder's syndrome block checks.
- Reset (asynchronous, sys_rst_n=0):
  - All outputs are 0 except din_ready=1.
  - State is IDLE; LFSR r[0..15]=0; counters are 0.
  - Reset asserted mid-frame discards the frame with no abort pulse.
- States:
  - IDLE: din_ready=1. An accepted symbol with din_sop=1 clears the LFSR, loads the first symbol, sets msg_cnt=1, and moves to MSG. Accepted symbols without din_sop are dropped.
  - MSG: din_ready=1.
    - Each accepted symbol updates the LFSR: fb = din ^ r[15]; r[i] <= r[i-1] ^ fb*G[i]; r[0] <= fb*G[0].
    - msg_cnt increments per accepted symbol. When the accepted symbol has msg_cnt==238, the state moves to PARITY and par_cnt=0.
    - din_valid gaps are allowed: the counter and LFSR hold, and dout_valid=0 on the corresponding output cycle.
  - PARITY: din_ready=0; din is ignored.
    - Each cycle dout <= r[15], then r[i] <= r[i-1] and r[0] <= 0.
    - par_cnt increments each cycle. On par_cnt==15 the state moves to IDLE.
    - There is no output backpressure; PARITY always lasts exactly 16 cycles.
- Latency and timing:
  - A symbol accepted in cycle c appears on dout in cycle c+1 with dout_valid=1.
  - If the last message symbol is accepted in cycle c, parity appears on dout in cycles c+2..c+17. There is no bubble; dout_eop=1 in cycle c+17.
  - din_ready=0 in cycles c+1..c+16 and returns to 1 in c+17. A din_sop accepted in c+17 gives dout_sop in c+18, so back-to-back output frames are contiguous.
- Output flags:
  - dout_sop is 1 only alongside the first message symbol.
  - dout_parity is 1 for all 16 parity symbols.
  - dout_eop is 1 only for parity symbol 15.
- Abort (din_sop accepted while in MSG):
  - frame_abort pulses in the next cycle.
  - The LFSR is reinitialised from the new symbol and msg_cnt=1.
  - The new symbol is output with dout_sop=1. The partial frame never receives parity.
- GF arithmetic: constant multipliers are XOR networks; addition is XOR. All widths are m bits with no carries.

Decomposition:
- Shared package rs_pkg:
  - N, K, T, M
  - PRIM_POLY = 9'h11D
  - G_COEF[0..15], the generator coefficients, excluding the monic x^16 term
  - state enum {IDLE, MSG, PARITY}
- Sub-module gf_const_mul_std: a parameterised standard-basis constant multiplier (const C, in m bits, out m bits), instantiated 16 times with G_COEF[i].

Test Plan:
- All-zero message, 239 consecutive symbols -> dout = 239 zeros then 16 zero parity symbols; dout_sop at symbol 0, dout_eop at symbol 254, dout_parity high for exactly 16 cycles.
- Message 0x00 x238 then 0x01 -> parity emitted is G_COEF[15], G_COEF[14], ..., G_COEF[0].
- Random messages, with codewords fed to the existing syndrome calculator -> all 16 syndromes = 0x00. Flipping one codeword symbol before syndrome, BM and Chien -> the decoder flags exactly that position.
- din_valid toggled 1/0 every other cycle during MSG -> identical parity to the gap-free run; dout_valid mirrors the gaps with 1-cycle delay.
- New din_sop at message symbol 100 -> frame_abort pulses once; the next 255 output symbols form a valid codeword (syndromes zero); no parity is emitted for the aborted frame.
- sys_rst_n pulsed low during PARITY symbol 5 -> outputs are immediately 0 and din_ready=1; the next frame encodes correctly. Back-to-back frames: 255 contiguous dout_valid cycles per frame and 16 din_ready=0 cycles between message blocks.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared RS(255,239) parameters, generator polynomial and FSM state type.
package rs_pkg;

    localparam int unsigned N    = 255;
    localparam int unsigned K    = 239;
    localparam int unsigned T    = 8;
    localparam int unsigned M    = 8;
    localparam int unsigned NPAR = 2 * T;

    localparam logic [8:0] PRIM_POLY = 9'h11D;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MSG    = 2'd1,
        PARITY = 2'd2
    } state_e;

    // Standard-basis GF(2^8) multiply; with one constant operand this folds to XORs.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < int'(M); i++) begin
            if (b[i]) acc ^= sh;
            sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? PRIM_POLY[M-1:0] : M'(0));
        end
        return acc;
    endfunction

    // g(x) = prod (x + alpha^i), i = 0..NPAR-1; returns the non-monic coefficients g[0..NPAR-1].
    function automatic logic [NPAR-1:0][M-1:0] gen_poly();
        logic [NPAR:0][M-1:0] g;
        logic [M-1:0]         root;
        g    = '0;
        g[0] = M'(1);
        root = M'(1);
        for (int i = 0; i < int'(NPAR); i++) begin
            for (int j = int'(NPAR); j > 0; j--) begin
                g[j] = g[j-1] ^ gf_mul(g[j], root);
            end
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, M'(2));
        end
        return g[NPAR-1:0];
    endfunction

    localparam logic [NPAR-1:0][M-1:0] G_COEF = gen_poly();

endpackage

// File: rtl/gf_const_mul_std.sv
// Multiply a GF(2^8) symbol by a fixed constant (pure XOR network).
module gf_const_mul_std
    import rs_pkg::*;
#(
    parameter logic [M-1:0] C = M'(1)
) (
    input  logic [M-1:0] in_i,
    output logic [M-1:0] out_o
);

    // Constant operand lets synthesis reduce the shift-add to XOR gates.
    assign out_o = gf_mul(in_i, C);

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(255,239) encoder: passes 239 message symbols, then appends 16 parity symbols.
module rs_encoder
    import rs_pkg::*;
(
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic [M-1:0] din,
    input  logic         din_valid,
    input  logic         din_sop,
    output logic         din_ready,
    output logic [M-1:0] dout,
    output logic         dout_valid,
    output logic         dout_sop,
    output logic         dout_eop,
    output logic         dout_parity,
    output logic         frame_abort
);

    localparam int unsigned CNT_W = $clog2(K);
    localparam int unsigned PAR_W = $clog2(NPAR);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        msg_cnt_q, msg_cnt_d;
    logic [PAR_W-1:0]        par_cnt_q, par_cnt_d;
    logic [NPAR-1:0][M-1:0]  r_q, r_d;
    logic [NPAR-1:0][M-1:0]  prod;
    logic [NPAR-1:0][M-1:0]  lfsr_upd;
    logic [M-1:0]            fb;
    logic                    accept;

    logic                    ready_q, ready_d;
    logic [M-1:0]            dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic                    dout_sop_q, dout_sop_d;
    logic                    dout_eop_q, dout_eop_d;
    logic                    dout_parity_q, dout_parity_d;
    logic                    frame_abort_q, frame_abort_d;

    assign accept = din_valid & ready_q;

    // A start-of-frame symbol divides into an empty register, so the old tap is masked.
    assign fb = din ^ (din_sop ? M'(0) : r_q[NPAR-1]);

    for (genvar i = 0; i < int'(NPAR); i++) begin : g_mul
        gf_const_mul_std #(.C(G_COEF[i])) u_mul (
            .in_i  (fb),
            .out_o (prod[i])
        );
    end

    // One LFSR division step by g(x), restarting from zero on a new frame.
    always_comb begin
        lfsr_upd[0] = prod[0];
        for (int i = 1; i < int'(NPAR); i++) begin
            lfsr_upd[i] = (din_sop ? M'(0) : r_q[i-1]) ^ prod[i];
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d       = state_q;
        msg_cnt_d     = msg_cnt_q;
        par_cnt_d     = par_cnt_q;
        r_d           = r_q;
        dout_d        = '0;
        dout_valid_d  = 1'b0;
        dout_sop_d    = 1'b0;
        dout_eop_d    = 1'b0;
        dout_parity_d = 1'b0;
        frame_abort_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && din_sop) begin
                    r_d          = lfsr_upd;
                    msg_cnt_d    = CNT_W'(1);
                    dout_d       = din;
                    dout_valid_d = 1'b1;
                    dout_sop_d   = 1'b1;
                    state_d      = MSG;
                end
            end
            MSG: begin
                if (accept) begin
                    r_d          = lfsr_upd;
                    dout_d       = din;
                    dout_valid_d = 1'b1;
                    if (din_sop) begin
                        frame_abort_d = 1'b1;
                        dout_sop_d    = 1'b1;
                        msg_cnt_d     = CNT_W'(1);
                    end else if (msg_cnt_q == CNT_W'(K - 1)) begin
                        msg_cnt_d = '0;
                        par_cnt_d = '0;
                        state_d   = PARITY;
                    end else begin
                        msg_cnt_d = msg_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                dout_d        = r_q[NPAR-1];
                dout_valid_d  = 1'b1;
                dout_parity_d = 1'b1;
                r_d           = {r_q[NPAR-2:0], M'(0)};
                par_cnt_d     = par_cnt_q + PAR_W'(1);
                if (par_cnt_q == PAR_W'(NPAR - 1)) begin
                    dout_eop_d = 1'b1;
                    par_cnt_d  = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d != PARITY);
    end

    // State, counters, LFSR and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            msg_cnt_q     <= '0;
            par_cnt_q     <= '0;
            r_q           <= '0;
            ready_q       <= 1'b1;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            dout_sop_q    <= 1'b0;
            dout_eop_q    <= 1'b0;
            dout_parity_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            msg_cnt_q     <= msg_cnt_d;
            par_cnt_q     <= par_cnt_d;
            r_q           <= r_d;
            ready_q       <= ready_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            dout_sop_q    <= dout_sop_d;
            dout_eop_q    <= dout_eop_d;
            dout_parity_q <= dout_parity_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign din_ready   = ready_q;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign dout_sop    = dout_sop_q;
    assign dout_eop    = dout_eop_q;
    assign dout_parity = dout_parity_q;
    assign frame_abort = frame_abort_q;

endmodule
